fft_load_ctrl: RTL and testbench

//  Load controller directly downstream of the address-prepare stage.
//  - Drives ena_prepare and consumes its linear input_addr and bit-reversed fft_addr_prepare.
//  - Reads samples from the input buffer RAM at input_addr.
//  - Writes each sample into FFT working RAM at the matching bit-reversed address, latency-aligned.
//  - Signals done when a full frame is in the working RAM; the butterfly stages then start.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_align_pipe.sv | 54 +++++
 rtl/fft_load_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fft_load_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants, the load-controller state type and a small helper for
// the FFT front end (address-prepare stage, load controller, butterflies).
//   ADDR_WIDTH  address width shared by prepare stage and RAMs
//   DATA_WIDTH  sample width, {re[15:0], im[15:0]}
//   MAX_STAGE   largest supported log2(N)
//   load_state_t  IDLE / LOAD / DRAIN / DONE
//   pow2m1(stage) returns 2**stage-1 at ADDR_WIDTH bits
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam logic [3:0] MAX_STAGE = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } load_state_t;

    function automatic logic [ADDR_WIDTH-1:0] pow2m1(input logic [3:0] stage);
        logic [ADDR_WIDTH-1:0] one;
        one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        return (one << stage) - one;
    endfunction

endpackage

// File: rtl/fft_align_pipe.sv
// ---------------------------------------------------------------------------
// fft_align_pipe
// Fixed-depth shift register used to line up read data / read strobes with
// the bit-reversed write address coming out of the prepare stage.
// A DEPTH of 0 degenerates to a plain wire.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous reset, active-low (clears every stage)
//   flush  in   synchronous clear of every stage
//   din    in   WIDTH-bit input
//   dout   out  WIDTH-bit output, din delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module fft_align_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] stage_q;
            logic [DEPTH-1:0][WIDTH-1:0] stage_d;

            always_comb begin
                stage_d = stage_q;
                if (flush) begin
                    stage_d = '0;
                end else begin
                    stage_d[0] = din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fft_load_ctrl.sv
// ---------------------------------------------------------------------------
// fft_load_ctrl
// Loads one frame of N samples from the input buffer RAM into the FFT
// working RAM in bit-reversed order, using the address-prepare stage for the
// linear read address and the bit-reversed (+1) write address.
//   clk, rst_n         clock / asynchronous active-low reset
//   start, abort       frame request / cancel
//   stage_number       log2(N), 1..MAX_STAGE
//   max_point_fft      N-1, must be 2**stage_number-1
//   ena_prepare        enable to the prepare stage (high while reading)
//   input_addr         linear address from the prepare stage
//   fft_addr_prepare   bit-reversed address +1, ADDR_LAG cycles behind
//   in_rd_en/addr/data input RAM read port (data RD_LAT cycles after en)
//   fft_wr_en/addr/data working RAM write port
//   busy               high in LOAD and DRAIN
//   done               one-cycle pulse when the whole frame is written
//   err_cfg            one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module fft_load_ctrl
    import fft_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int ADDR_LAG = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3:0]            stage_number,
    input  logic [ADDR_WIDTH-1:0] max_point_fft,
    output logic                  ena_prepare,
    input  logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [ADDR_WIDTH-1:0] fft_addr_prepare,
    output logic                  in_rd_en,
    output logic [ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [DATA_WIDTH-1:0] in_rd_data,
    output logic                  fft_wr_en,
    output logic [ADDR_WIDTH-1:0] fft_wr_addr,
    output logic [DATA_WIDTH-1:0] fft_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg
);

    localparam int DATA_DLY = ADDR_LAG - RD_LAT;
    localparam int DRAIN_W  = (ADDR_LAG < 1) ? 1 : $clog2(ADDR_LAG + 1);
    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    load_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic                  err_cfg_q, err_cfg_d;

    logic                  cfg_ok;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data_dly;

    assign cfg_ok = (stage_number != 4'd0) &&
                    (stage_number <= MAX_STAGE) &&
                    (max_point_fft == pow2m1(stage_number));

    // DRAIN lasts ADDR_LAG+1 cycles: the last read needs ADDR_LAG cycles to
    // reach the write port, and one more cycle lets the valid pipe show empty
    // before done is raised. Abort overrides everything, including a start
    // arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        n_d         = n_q;
        drain_cnt_d = drain_cnt_q;
        err_cfg_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state_d  = LOAD;
                            n_d      = max_point_fft + ONE;
                            rd_cnt_d = '0;
                        end else begin
                            err_cfg_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    rd_cnt_d = rd_cnt_q + ONE;
                    if (rd_cnt_q == n_q - ONE) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                DRAIN: begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                    if (drain_cnt_q == DRAIN_W'(ADDR_LAG)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            n_q         <= '0;
            drain_cnt_q <= '0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            n_q         <= n_d;
            drain_cnt_q <= drain_cnt_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    assign ena_prepare = (state_q == LOAD);
    assign in_rd_en    = (state_q == LOAD);
    assign in_rd_addr  = in_rd_en ? input_addr : '0;
    assign busy        = (state_q == LOAD) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign err_cfg     = err_cfg_q;

    // Read strobes travel the full address lag; the data only needs the part
    // of the lag not already covered by the RAM read latency.
    fft_align_pipe #(
        .DEPTH (ADDR_LAG),
        .WIDTH (1)
    ) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .din   (in_rd_en),
        .dout  (wr_valid)
    );

    fft_align_pipe #(
        .DEPTH (DATA_DLY),
        .WIDTH (DATA_WIDTH)
    ) u_data_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .din   (in_rd_data),
        .dout  (wr_data_dly)
    );

    // Address and data are forced to 0 between writes so the write port is
    // quiet whenever fft_wr_en is low.
    assign fft_wr_en   = wr_valid;
    assign fft_wr_addr = wr_valid ? fft_addr_prepare : '0;
    assign fft_wr_data = wr_valid ? wr_data_dly : '0;

endmodule

// File: tb/tb_fft_load_ctrl.sv
module tb_fft_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  stage_number;
    logic [11:0] max_point_fft;
    logic        ena_prepare;
    logic [11:0] input_addr;
    logic [11:0] fft_addr_prepare;
    logic        in_rd_en;
    logic [11:0] in_rd_addr;
    logic [31:0] in_rd_data;
    logic        fft_wr_en;
    logic [11:0] fft_wr_addr;
    logic [31:0] fft_wr_data;
    logic        busy;
    logic        done;
    logic        err_cfg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Prepare-stage and input-RAM models
    logic [11:0] prep_cnt;
    logic [11:0] prep_p1;
    logic [11:0] prep_p2;
    int          prep_stage = 3;
    logic [31:0] mem [0:4095];

    // Monitor records
    int          wr_cyc[$];
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cyc[$];
    int          err_cnt;
    bit          ena_seen;
    bit          busy_seen;

    fft_load_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .stage_number     (stage_number),
        .max_point_fft    (max_point_fft),
        .ena_prepare      (ena_prepare),
        .input_addr       (input_addr),
        .fft_addr_prepare (fft_addr_prepare),
        .in_rd_en         (in_rd_en),
        .in_rd_addr       (in_rd_addr),
        .in_rd_data       (in_rd_data),
        .fft_wr_en        (fft_wr_en),
        .fft_wr_addr      (fft_wr_addr),
        .fft_wr_data      (fft_wr_data),
        .busy             (busy),
        .done             (done),
        .err_cfg          (err_cfg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] prepRev(input logic [11:0] x, input int s);
        logic [11:0] r;
        r = '0;
        for (int b = 0; b < s; b++) r[s-1-b] = x[b];
        return r;
    endfunction

    // Prepare stage: counter held at 0 while disabled, bit-reversed +1
    // address appears two cycles after the linear address.
    assign input_addr       = prep_cnt;
    assign fft_addr_prepare = prep_p2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prep_cnt <= '0;
            prep_p1  <= '0;
            prep_p2  <= '0;
        end else begin
            prep_cnt <= ena_prepare ? prep_cnt + 12'd1 : 12'd0;
            prep_p1  <= prepRev(prep_cnt, prep_stage) + 12'd1;
            prep_p2  <= prep_p1;
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + i;
    end

    always @(posedge clk) begin
        if (in_rd_en) in_rd_data <= mem[in_rd_addr];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (fft_wr_en) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(int'(fft_wr_addr));
                wr_data.push_back(fft_wr_data);
            end
            if (done)        done_cyc.push_back(cyc);
            if (err_cfg)     err_cnt++;
            if (ena_prepare) ena_seen = 1'b1;
            if (busy)        busy_seen = 1'b1;
        end
    end

    // Reference: bit reversal of k over s bits by repeated halving.
    function automatic int refRev(input int k, input int s);
        int r;
        int x;
        r = 0;
        x = k;
        for (int b = 0; b < s; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearRecords();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cyc.delete();
        err_cnt   = 0;
        ena_seen  = 1'b0;
        busy_seen = 1'b0;
    endtask

    // One start pulse, then cycle-relative extra starts, an optional abort,
    // and scrambled config inputs; expectations come from the frame rules.
    task automatic applyStimulus(input int s, input int m, input int abort_off,
                                 input int x1, input int x2);
        int  n;
        int  sc;
        int  nexp;
        int  limit;
        int  ndone;
        int  uniq;
        bit  legal;
        bit  hit [int];
        legal = (s >= 1) && (s <= 10) && (m == (2 ** s) - 1);
        n     = legal ? (2 ** s) : 0;
        limit = n + 12;
        clearRecords();
        @(negedge clk);
        stage_number  = 4'(s);
        max_point_fft = 12'(m);
        prep_stage    = s;
        start         = 1'b1;
        sc            = cyc;
        for (int rel = 1; rel <= limit; rel++) begin
            @(negedge clk);
            start         = (rel == x1) || (rel == x2);
            abort         = (rel == abort_off);
            stage_number  = 4'($urandom_range(0, 15));
            max_point_fft = 12'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        if (!legal) begin
            checkOutput("err_cfg_pulses", err_cnt, 1);
            checkOutput("bad_cfg_writes", wr_cyc.size(), 0);
            checkOutput("bad_cfg_ena", ena_seen, 0);
            checkOutput("bad_cfg_busy", busy_seen, 0);
            checkOutput("bad_cfg_done", done_cyc.size(), 0);
        end else begin
            nexp = n;
            if (abort_off > 0) begin
                nexp = abort_off - 2;
                if (nexp < 0) nexp = 0;
                if (nexp > n) nexp = n;
            end
            ndone = (abort_off > 0 && abort_off <= n + 3) ? 0 : 1;
            checkOutput("wr_count", wr_cyc.size(), nexp);
            checkOutput("err_cfg_none", err_cnt, 0);
            checkOutput("done_count", done_cyc.size(), ndone);
            if (ndone == 1 && done_cyc.size() > 0)
                checkOutput("done_cycle", done_cyc[0] - sc, n + 4);
            uniq = 0;
            for (int k = 0; k < wr_cyc.size() && k < nexp; k++) begin
                checkOutput($sformatf("wr_addr[%0d]", k), wr_addr[k], refRev(k, s) + 1);
                checkOutput($sformatf("wr_data[%0d]", k), wr_data[k], 32'hA000_0000 + k);
                checkOutput($sformatf("wr_cycle[%0d]", k), wr_cyc[k] - sc, 3 + k);
                if (!hit.exists(wr_addr[k])) uniq++;
                hit[wr_addr[k]] = 1'b1;
            end
            checkOutput("wr_unique_addrs", uniq, nexp);
        end
    endtask

    initial begin
        int s;
        int n;
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        stage_number  = 4'd0;
        max_point_fft = 12'd0;
        clearRecords();
        #1;
        checkOutput("rst_ena_prepare", ena_prepare, 0);
        checkOutput("rst_in_rd_en", in_rd_en, 0);
        checkOutput("rst_in_rd_addr", in_rd_addr, 0);
        checkOutput("rst_fft_wr_en", fft_wr_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_cfg", err_cfg, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", busy, 0);

        $display("[TB] step 1: stage 3 frame");
        applyStimulus(3, 7, 0, 0, 0);

        $display("[TB] step 2: mismatched config");
        applyStimulus(4, 8, 0, 0, 0);

        $display("[TB] step 3: stage 10 frame");
        applyStimulus(10, 1023, 0, 0, 0);

        $display("[TB] step 4: abort on 4th LOAD cycle, then full frame");
        applyStimulus(3, 7, 4, 0, 0);
        applyStimulus(3, 7, 0, 0, 0);

        $display("[TB] step 5: starts during LOAD and DONE ignored");
        applyStimulus(3, 7, 0, 3, 12);

        $display("[TB] step 6: async reset mid-frame");
        clearRecords();
        @(negedge clk);
        stage_number  = 4'd3;
        max_point_fft = 12'd7;
        prep_stage    = 3;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ena", ena_prepare, 0);
        checkOutput("async_rst_rd_en", in_rd_en, 0);
        checkOutput("async_rst_wr_en", fft_wr_en, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(3, 7, 0, 0, 0);

        $display("[TB] step 7: abort/start same cycle");
        applyStimulus(2, 3, 1, 1, 0);

        $display("[TB] step 8: randomized frames");
        for (int r = 0; r < 8; r++) begin
            s = $urandom_range(1, 5);
            n = 2 ** s;
            if ($urandom_range(0, 1) == 1)
                applyStimulus(s, n - 1, $urandom_range(1, n + 3), 0, 0);
            else
                applyStimulus(s, n - 1, 0, 0, 0);
        end
        for (int r = 0; r < 4; r++) begin
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 4095), 0, 0, 0);
        end
        applyStimulus(1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
